// File: rtl/prog_tick_pkg.sv
// Shared constants and the config FSM state type for the programmable tick comparator.
package prog_tick_pkg;

    localparam int SEL_TERM         = 0;
    localparam int SEL_CH_BASE      = 1;
    localparam int TERM_RST_DEFAULT = 99999;

    typedef enum logic [1:0] {
        IDLE_READY,
        PENDING,
        APPLY
    } cfg_state_t;

endpackage

// File: rtl/prog_tick_comparator_match_channel.sv
// One match channel: a loadable threshold and a registered equality compare against the counter.
module match_channel
    import prog_tick_pkg::*;
#(
    parameter int WIDTH    = 17,
    parameter int TERM_RST = TERM_RST_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             active,
    input  logic [WIDTH-1:0] count,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             match
);

    localparam logic [WIDTH-1:0] THR_INIT = WIDTH'(TERM_RST - 1);

    logic [WIDTH-1:0] thr;
    logic             match_p1;

    // Compare sees the old threshold on a load edge; the new one governs the next period.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            thr      <= THR_INIT;
            match_p1 <= 1'b0;
        end else begin
            if (load) begin
                thr <= data;
            end
            match_p1 <= active && (count == thr);
        end
    end

    assign match = match_p1;

endmodule

// File: rtl/prog_tick_comparator.sv
// Prescale counter with programmable terminal count, NCH match channels, one-shot mode
// and a shadowed config port that only updates at period boundaries or while idle.
module prog_tick_comparator
    import prog_tick_pkg::*;
#(
    parameter int WIDTH    = 17,
    parameter int NCH      = 2,
    parameter int TERM_RST = TERM_RST_DEFAULT,
    parameter int SELW     = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             ONESHOT,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [SELW-1:0]  CFG_SEL,
    input  logic [WIDTH-1:0] CFG_DATA,
    output logic             TICK,
    output logic [NCH-1:0]   MATCH,
    output logic [WIDTH-1:0] COUNT,
    output logic             DONE
);

    localparam logic [SELW-1:0] SEL_MAX = SELW'(NCH);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] pend_data;
    logic [SELW-1:0]  pend_sel;
    logic             done_q;
    logic             en_q;
    logic             tick_p1;
    logic             ready_q;
    cfg_state_t       state;

    logic             active;
    logic             wrap;
    logic             idle;
    logic             apply;
    logic             apply_term;
    logic [NCH-1:0]   thr_load;

    assign active     = EN & ~done_q & ~CLR;
    assign wrap       = active & (count_q == term_q);
    assign idle       = ~EN | done_q;
    assign apply      = (state == PENDING) & (CLR | idle | wrap);
    assign apply_term = apply & (pend_sel == SELW'(SEL_TERM));

    // Counter, one-shot completion and period tick
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
            term_q  <= WIDTH'(TERM_RST);
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            tick_p1 <= 1'b0;
        end else begin
            en_q    <= EN;
            tick_p1 <= wrap;
            if (apply_term) begin
                term_q <= pend_data;
            end
            if (CLR) begin
                count_q <= '0;
                done_q  <= 1'b0;
            end else if (active) begin
                if (wrap) begin
                    count_q <= '0;
                    if (ONESHOT) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    count_q <= count_q + WIDTH'(1);
                end
            end else begin
                // A shrinking terminal count must never leave COUNT above it.
                if (apply_term && (count_q > pend_data)) begin
                    count_q <= '0;
                end
                if (done_q && EN && !en_q) begin
                    done_q <= 1'b0;
                end
            end
        end
    end

    // Config handshake: capture, wait for a safe apply point, then reopen
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE_READY;
            ready_q   <= 1'b1;
            pend_sel  <= '0;
            pend_data <= '0;
        end else begin
            case (state)
                IDLE_READY: begin
                    if (CFG_VALID) begin
                        pend_sel  <= CFG_SEL;
                        pend_data <= CFG_DATA;
                        ready_q   <= 1'b0;
                        state     <= (CFG_SEL > SEL_MAX) ? APPLY : PENDING;
                    end
                end
                PENDING: begin
                    if (apply) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    ready_q <= 1'b1;
                    state   <= IDLE_READY;
                end
                default: begin
                    state <= IDLE_READY;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign thr_load[i] = apply & (pend_sel == SELW'(SEL_CH_BASE + i));

        match_channel #(
            .WIDTH    (WIDTH),
            .TERM_RST (TERM_RST)
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .active (active),
            .count  (count_q),
            .load   (thr_load[i]),
            .data   (pend_data),
            .match  (MATCH[i])
        );
    end

    assign TICK      = tick_p1;
    assign COUNT     = count_q;
    assign DONE      = done_q;
    assign CFG_READY = ready_q;

endmodule

// File: tb/tb_prog_tick_comparator.sv
// Scoreboard bench: stimulus queues the expected TICK/MATCH pulses, a monitor pops them as they appear.
module tb_prog_tick_comparator;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;
    localparam int SELW  = 3;

    logic             CLK       = 1'b0;
    logic             RST       = 1'b0;
    logic             EN        = 1'b0;
    logic             CLR       = 1'b0;
    logic             ONESHOT   = 1'b0;
    logic             CFG_VALID = 1'b0;
    logic [SELW-1:0]  CFG_SEL   = '0;
    logic [WIDTH-1:0] CFG_DATA  = '0;
    logic             CFG_READY;
    logic             TICK;
    logic [NCH-1:0]   MATCH;
    logic [WIDTH-1:0] COUNT;
    logic             DONE;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] count;
        logic       tick;
        logic [1:0] match;
    } ev_t;

    ev_t exp_q[$];

    prog_tick_comparator #(
        .WIDTH    (WIDTH),
        .NCH      (NCH),
        .TERM_RST (9),
        .SELW     (SELW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .CLR       (CLR),
        .ONESHOT   (ONESHOT),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_SEL   (CFG_SEL),
        .CFG_DATA  (CFG_DATA),
        .TICK      (TICK),
        .MATCH     (MATCH),
        .COUNT     (COUNT),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic t, input logic [1:0] m);
        exp_q.push_back({c, t, m});
    endtask

    task automatic cfg_idle(input logic [SELW-1:0] sel, input logic [WIDTH-1:0] data);
        CFG_VALID = 1'b1;
        CFG_SEL   = sel;
        CFG_DATA  = data;
        step(1);
        CFG_VALID = 1'b0;
        check("cfg_busy", CFG_READY, 0);
        step(2);
        check("cfg_reopen", CFG_READY, 1);
    endtask

    // Monitor: every pulse the DUT shows must match the next queued expectation
    always @(negedge CLK) begin
        ev_t e;
        if (RST && (TICK || (MATCH != '0))) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got count=%0d tick=%0b match=%b, required no pulse",
                         COUNT, TICK, MATCH);
            end else begin
                e = exp_q.pop_front();
                if ({COUNT, TICK, MATCH} !== e) begin
                    bad++;
                    $display("FAIL pulse: got count=%0d tick=%0b match=%b, required count=%0d tick=%0b match=%b",
                             COUNT, TICK, MATCH, e.count, e.tick, e.match);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check("rst_count", COUNT, 0);
        check("rst_tick", TICK, 0);
        check("rst_match", MATCH, 0);
        check("rst_done", DONE, 0);
        check("rst_ready", CFG_READY, 1);

        // Free-running with defaults TERM=9, THR=8
        expect_ev(9, 0, 2'b11); expect_ev(0, 1, 2'b00);
        expect_ev(9, 0, 2'b11); expect_ev(0, 1, 2'b00);
        RST = 1'b1;
        EN  = 1'b1;
        step(20);
        check("p1_count", COUNT, 0);

        // Threshold write for channel 0 mid-period takes effect after the wrap
        expect_ev(9, 0, 2'b11); expect_ev(0, 1, 2'b00);
        expect_ev(4, 0, 2'b01); expect_ev(9, 0, 2'b10); expect_ev(0, 1, 2'b00);
        step(5);
        check("p2_count5", COUNT, 5);
        CFG_VALID = 1'b1;
        CFG_SEL   = 3'd1;
        CFG_DATA  = 8'd3;
        step(1);
        CFG_VALID = 1'b0;
        check("p2_ready_low", CFG_READY, 0);
        step(4);
        check("p2_wrap_count", COUNT, 0);
        check("p2_ready_at_wrap", CFG_READY, 0);
        step(1);
        check("p2_ready_back", CFG_READY, 1);
        step(9);

        // One-shot: one period, then sticky DONE until EN rises again
        EN      = 1'b0;
        ONESHOT = 1'b1;
        step(2);
        check("p3_hold0", COUNT, 0);
        expect_ev(4, 0, 2'b01); expect_ev(9, 0, 2'b10); expect_ev(0, 1, 2'b00);
        EN = 1'b1;
        step(10);
        check("p3_done", DONE, 1);
        step(5);
        check("p3_stopped", COUNT, 0);
        check("p3_done_sticky", DONE, 1);
        EN = 1'b0;
        step(1);
        expect_ev(4, 0, 2'b01); expect_ev(9, 0, 2'b10); expect_ev(0, 1, 2'b00);
        EN = 1'b1;
        step(1);
        check("p3_restart_done", DONE, 0);
        check("p3_restart_count", COUNT, 0);
        step(10);
        check("p3_done2", DONE, 1);
        ONESHOT = 1'b0;
        EN      = 1'b0;
        CLR     = 1'b1;
        step(1);
        CLR = 1'b0;
        check("clr_done", DONE, 0);
        check("clr_count", COUNT, 0);

        // TERM=0: tick on every active cycle; then an out-of-range select is dropped
        cfg_idle(3'd0, 8'd0);
        expect_ev(0, 1, 2'b00); expect_ev(0, 1, 2'b00);
        expect_ev(0, 1, 2'b00); expect_ev(0, 1, 2'b00);
        EN = 1'b1;
        step(4);
        check("p4_count0", COUNT, 0);
        EN        = 1'b0;
        CFG_VALID = 1'b1;
        CFG_SEL   = 3'd5;
        CFG_DATA  = 8'd7;
        step(1);
        CFG_VALID = 1'b0;
        check("p4_drop_busy", CFG_READY, 0);
        step(1);
        check("p4_drop_reopen", CFG_READY, 1);
        cfg_idle(3'd0, 8'd9);
        cfg_idle(3'd1, 8'd8);

        // Pause holds COUNT; the tick arrives 4 active cycles after resuming at 6
        EN = 1'b1;
        step(6);
        check("p5_count6", COUNT, 6);
        EN = 1'b0;
        step(5);
        check("p5_hold", COUNT, 6);
        expect_ev(9, 0, 2'b11); expect_ev(0, 1, 2'b00);
        EN = 1'b1;
        step(4);
        check("p5_resume_wrap", COUNT, 0);

        // Reset with a pending channel-1 write: everything returns to defaults
        step(3);
        CFG_VALID = 1'b1;
        CFG_SEL   = 3'd2;
        CFG_DATA  = 8'd2;
        step(1);
        CFG_VALID = 1'b0;
        check("p6_pending", CFG_READY, 0);
        step(1);
        RST = 1'b0;
        #1;
        check("p6_rst_count", COUNT, 0);
        check("p6_rst_tick", TICK, 0);
        check("p6_rst_match", MATCH, 0);
        check("p6_rst_done", DONE, 0);
        check("p6_rst_ready", CFG_READY, 1);
        step(2);
        expect_ev(9, 0, 2'b11); expect_ev(0, 1, 2'b00);
        RST = 1'b1;
        step(10);
        check("p6_count", COUNT, 0);
        step(2);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
